// File: rtl/fwd_scoreboard_if.sv
// Issue/bypass bundle between the ID stage and the forwarding scoreboard.
// The master side is the ID stage; the slave side is the scoreboard.
interface fwd_scoreboard_if #(
  parameter int AW      = 4,
  parameter int DEPTH   = 3,
  parameter int NUM_SRC = 2
) ();
  localparam int SELW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);

  logic                    stall;
  logic                    flush;
  logic                    issue_valid;
  logic                    issue_wr_en;
  logic [AW-1:0]           issue_rd;
  logic                    issue_is_load;
  logic [NUM_SRC*AW-1:0]   src_addr;
  logic [NUM_SRC-1:0]      src_used;
  logic                    load_use_stall;
  logic [NUM_SRC*SELW-1:0] fwd_sel;
  logic [CW-1:0]           pending_cnt;

  modport master (
    output stall, flush, issue_valid, issue_wr_en, issue_rd, issue_is_load,
           src_addr, src_used,
    input  load_use_stall, fwd_sel, pending_cnt
  );

  modport slave (
    input  stall, flush, issue_valid, issue_wr_en, issue_rd, issue_is_load,
           src_addr, src_used,
    output load_use_stall, fwd_sel, pending_cnt
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit: tracks in-flight writers through EX..WB
// and produces registered per-operand bypass selects for the instruction in EX.
module fwd_scoreboard #(
  parameter int AW       = 4,
  parameter int DEPTH    = 3,
  parameter int NUM_SRC  = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input logic             clk,
  input logic             rst,
  fwd_scoreboard_if.slave bus
);
  localparam int SELW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          v;
    logic [AW-1:0] rd;
    logic          ld;
  } entry_t;

  entry_t [DEPTH-1:0]                e_q;
  logic   [NUM_SRC-1:0][DEPTH-1:0]   match;
  logic   [NUM_SRC-1:0][SELW-1:0]    sel_d;
  logic   [NUM_SRC-1:0][SELW-1:0]    sel_q;
  logic   [CW-1:0]                   cnt_d;
  logic   [CW-1:0]                   cnt_q;
  logic                              lu_hit;
  logic                              lus;
  logic                              accept;
  entry_t                            e0_d;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    match  = '0;
    lu_hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        match[k][i] = bus.src_used[k] & e_q[i].v
                    & (e_q[i].rd == bus.src_addr[k*AW +: AW])
                    & !(ZERO_REG && (bus.src_addr[k*AW +: AW] == '0));
      end
      lu_hit = lu_hit | (match[k][0] & e_q[0].ld);
    end
  end

  assign lus    = bus.issue_valid & ~bus.flush & lu_hit;
  assign accept = bus.issue_valid & ~bus.flush & ~lus;

  // Walk from the oldest usable stage down so the youngest producer wins.
  // The last stage is skipped because the register file writes through.
  always_comb begin
    sel_d = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = DEPTH - 2; i >= 0; i--) begin
        if (match[k][i]) sel_d[k] = SELW'(i + 1);
      end
    end
  end

  always_comb begin
    e0_d.v  = accept & bus.issue_wr_en & !(ZERO_REG && (bus.issue_rd == '0));
    e0_d.rd = bus.issue_rd;
    e0_d.ld = bus.issue_is_load;
    cnt_d   = CW'(e0_d.v);
    for (int i = 0; i < DEPTH - 1; i++) begin
      cnt_d = cnt_d + CW'(e_q[i].v);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, matching the real pipeline registers.
  // NOTE: the entry array is small tracking state and is reset so no stale
  // valid bit can forward garbage after a mid-run reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q   <= '0;
      sel_q <= '0;
      cnt_q <= '0;
    end else if (!bus.stall) begin
      e_q   <= {e_q[DEPTH-2:0], e0_d};
      sel_q <= accept ? sel_d : '0;
      cnt_q <= cnt_d;
    end
  end

  assign bus.load_use_stall = lus;
  assign bus.fwd_sel        = sel_q;
  assign bus.pending_cnt    = cnt_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed vector table, reset/stall sequences and
// random traffic compared against an instruction-history reference model.
module tb_fwd_scoreboard;
  localparam int AW      = 4;
  localparam int DEPTH   = 3;
  localparam int NUM_SRC = 2;
  localparam int SELW    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fwd_scoreboard_if #(.AW(AW), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC)) bus ();

  fwd_scoreboard #(
    .AW(AW), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .ZERO_REG(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string  tag;
    bit     stall, flush, valid, wr;
    int     rd;
    bit     ld;
    int     s0, s1;
    bit [1:0] used;
    bit     lus;
    int     sel0, sel1, cnt;
  } vec_t;

  function automatic vec_t mk(input string tag, input bit stall, flush, valid, wr,
                              input int rd, input bit ld, input int s0, s1,
                              input bit [1:0] used, input bit lus,
                              input int sel0, sel1, cnt);
    vec_t v;
    v.tag = tag; v.stall = stall; v.flush = flush; v.valid = valid; v.wr = wr;
    v.rd = rd; v.ld = ld; v.s0 = s0; v.s1 = s1; v.used = used;
    v.lus = lus; v.sel0 = sel0; v.sel1 = sel1; v.cnt = cnt;
    return v;
  endfunction

  task automatic apply(input bit stall, flush, valid, wr, input int rd,
                       input bit ld, input int s0, s1, input bit [1:0] used);
    bus.stall         = stall;
    bus.flush         = flush;
    bus.issue_valid   = valid;
    bus.issue_wr_en   = wr;
    bus.issue_rd      = AW'(rd);
    bus.issue_is_load = ld;
    bus.src_addr      = {AW'(s1), AW'(s0)};
    bus.src_used      = used;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    apply(v.stall, v.flush, v.valid, v.wr, v.rd, v.ld, v.s0, v.s1, v.used);
    #1 check({v.tag, ".lus"}, 32'(bus.load_use_stall), int'(v.lus));
    @(posedge clk);
    #1;
    check({v.tag, ".sel0"}, 32'(bus.fwd_sel[SELW-1:0]), v.sel0);
    check({v.tag, ".sel1"}, 32'(bus.fwd_sel[2*SELW-1:SELW]), v.sel1);
    check({v.tag, ".cnt"}, 32'(bus.pending_cnt), v.cnt);
  endtask

  // Reference model: history of what entered EX each unstalled cycle,
  // youngest first. A slot is a register writer or a bubble.
  typedef struct { bit wr; int rd; bit ld; } slot_t;
  slot_t hist[$];
  int exp_sel0, exp_sel1, exp_cnt;

  function automatic int m_sel(input int src, input bit used);
    if (!used || src == 0) return 0;
    for (int a = 0; a < DEPTH - 1 && a < hist.size(); a++)
      if (hist[a].wr && hist[a].rd == src) return a + 1;
    return 0;
  endfunction

  function automatic bit m_lus(input bit valid, flush, input int s0, s1,
                               input bit [1:0] used);
    if (!valid || flush || hist.size() == 0) return 1'b0;
    if (!(hist[0].wr && hist[0].ld)) return 1'b0;
    return (used[0] && s0 != 0 && hist[0].rd == s0) ||
           (used[1] && s1 != 0 && hist[0].rd == s1);
  endfunction

  task automatic model_step(input bit stall, flush, valid, wr, input int rd,
                            input bit ld, input int s0, s1, input bit [1:0] used);
    bit    acc;
    slot_t s;
    if (stall) return;
    acc = valid && !flush && !m_lus(valid, flush, s0, s1, used);
    exp_sel0 = acc ? m_sel(s0, used[0]) : 0;
    exp_sel1 = acc ? m_sel(s1, used[1]) : 0;
    s.wr = acc && wr && rd != 0;
    s.rd = rd;
    s.ld = ld;
    hist.push_front(s);
    if (hist.size() > DEPTH) void'(hist.pop_back());
    exp_cnt = 0;
    foreach (hist[a]) if (hist[a].wr) exp_cnt++;
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    #1;
    check("reset.lus", 32'(bus.load_use_stall), 0);
    check("reset.sel", 32'(bus.fwd_sel), 0);
    check("reset.cnt", 32'(bus.pending_cnt), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    //           tag        stl fl vld wr rd ld s0 s1 used  lus s0 s1 cnt
    tbl.push_back(mk("fwd1_add", 0,0,1,1,3,0, 1,2,2'b11, 0,0,0,1));
    tbl.push_back(mk("fwd1_sub", 0,0,1,1,1,0, 3,2,2'b11, 0,1,0,2));
    tbl.push_back(mk("nop",      0,0,0,0,0,0, 0,0,2'b00, 0,0,0,2));
    tbl.push_back(mk("nop",      0,0,0,0,0,0, 0,0,2'b00, 0,0,0,1));
    tbl.push_back(mk("nop",      0,0,0,0,0,0, 0,0,2'b00, 0,0,0,0));
    tbl.push_back(mk("fwd2_add", 0,0,1,1,3,0, 1,2,2'b11, 0,0,0,1));
    tbl.push_back(mk("fwd2_nop", 0,0,0,0,0,0, 0,0,2'b00, 0,0,0,1));
    tbl.push_back(mk("fwd2_sub", 0,0,1,1,7,0, 1,3,2'b11, 0,0,2,2));
    tbl.push_back(mk("far",      0,0,1,0,0,0, 3,3,2'b11, 0,0,0,1));
    tbl.push_back(mk("nop",      0,0,0,0,0,0, 0,0,2'b00, 0,0,0,1));
    tbl.push_back(mk("nop",      0,0,0,0,0,0, 0,0,2'b00, 0,0,0,0));
    tbl.push_back(mk("yw_a",     0,0,1,1,3,0, 1,2,2'b11, 0,0,0,1));
    tbl.push_back(mk("yw_b",     0,0,1,1,3,0, 1,2,2'b11, 0,0,0,2));
    tbl.push_back(mk("yw_c",     0,0,1,0,0,0, 3,3,2'b11, 0,1,1,2));
    tbl.push_back(mk("nop",      0,0,0,0,0,0, 0,0,2'b00, 0,0,0,1));
    tbl.push_back(mk("nop",      0,0,0,0,0,0, 0,0,2'b00, 0,0,0,0));
    tbl.push_back(mk("lu_lw",    0,0,1,1,5,1, 2,0,2'b01, 0,0,0,1));
    tbl.push_back(mk("lu_hold",  0,0,1,1,6,0, 5,5,2'b11, 1,0,0,1));
    tbl.push_back(mk("lu_go",    0,0,1,1,6,0, 5,5,2'b11, 0,2,2,2));
    tbl.push_back(mk("nop",      0,0,0,0,0,0, 0,0,2'b00, 0,0,0,1));
    tbl.push_back(mk("nop",      0,0,0,0,0,0, 0,0,2'b00, 0,0,0,1));
    tbl.push_back(mk("nop",      0,0,0,0,0,0, 0,0,2'b00, 0,0,0,0));
    tbl.push_back(mk("fl_lw",    0,0,1,1,5,1, 2,0,2'b01, 0,0,0,1));
    tbl.push_back(mk("fl_use",   0,1,1,1,6,0, 5,5,2'b11, 0,0,0,1));
    tbl.push_back(mk("nop",      0,0,0,0,0,0, 0,0,2'b00, 0,0,0,1));
    tbl.push_back(mk("nop",      0,0,0,0,0,0, 0,0,2'b00, 0,0,0,0));
    tbl.push_back(mk("zr_wr",    0,0,1,1,0,0, 1,2,2'b11, 0,0,0,0));
    tbl.push_back(mk("zr_use",   0,0,1,0,0,0, 0,0,2'b11, 0,0,0,0));
    tbl.push_back(mk("used_p",   0,0,1,1,4,0, 1,2,2'b11, 0,0,0,1));
    tbl.push_back(mk("used_c",   0,0,1,0,0,0, 1,4,2'b01, 0,0,0,1));
    tbl.push_back(mk("nop",      0,0,0,0,0,0, 0,0,2'b00, 0,0,0,1));
    tbl.push_back(mk("nop",      0,0,0,0,0,0, 0,0,2'b00, 0,0,0,0));
    tbl.push_back(mk("st_p",     0,0,1,1,4,0, 1,2,2'b11, 0,0,0,1));
    tbl.push_back(mk("st_hold",  1,0,1,0,0,0, 4,2,2'b11, 0,0,0,1));
    tbl.push_back(mk("st_hold",  1,0,1,0,0,0, 4,2,2'b11, 0,0,0,1));
    tbl.push_back(mk("st_hold",  1,0,1,0,0,0, 4,2,2'b11, 0,0,0,1));
    tbl.push_back(mk("st_rel",   0,0,1,0,0,0, 4,2,2'b11, 0,1,0,1));
    tbl.push_back(mk("st_hold2", 1,0,0,0,0,0, 0,0,2'b00, 0,1,0,1));
    tbl.push_back(mk("nop",      0,0,0,0,0,0, 0,0,2'b00, 0,0,0,1));
    tbl.push_back(mk("nop",      0,0,0,0,0,0, 0,0,2'b00, 0,0,0,0));
    tbl.push_back(mk("lst_lw",   0,0,1,1,5,1, 2,0,2'b01, 0,0,0,1));
    tbl.push_back(mk("lst_stl",  1,0,1,1,6,0, 5,5,2'b11, 1,0,0,1));
    tbl.push_back(mk("lst_hold", 0,0,1,1,6,0, 5,5,2'b11, 1,0,0,1));
    tbl.push_back(mk("lst_go",   0,0,1,1,6,0, 5,5,2'b11, 0,2,2,2));
    tbl.push_back(mk("nop",      0,0,0,0,0,0, 0,0,2'b00, 0,0,0,1));
    tbl.push_back(mk("nop",      0,0,0,0,0,0, 0,0,2'b00, 0,0,0,1));
    tbl.push_back(mk("nop",      0,0,0,0,0,0, 0,0,2'b00, 0,0,0,0));
    foreach (tbl[i]) run_vec(tbl[i]);

    // Mid-run reset with three writers in flight and a live bypass select.
    run_vec(mk("rs_w1", 0,0,1,1,1,0, 0,0,2'b00, 0,0,0,1));
    run_vec(mk("rs_w2", 0,0,1,1,2,0, 0,0,2'b00, 0,0,0,2));
    run_vec(mk("rs_w3", 0,0,1,1,3,0, 2,0,2'b01, 0,1,0,3));
    @(negedge clk);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    #2 rst = 1'b1;
    #1;
    check("rs_async.cnt", 32'(bus.pending_cnt), 0);
    check("rs_async.sel", 32'(bus.fwd_sel), 0);
    check("rs_async.lus", 32'(bus.load_use_stall), 0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(mk("rs_after", 0,0,1,0,0,0, 3,2,2'b11, 0,0,0,0));

    // Random traffic against the history model, starting from reset.
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    hist.delete();
    exp_sel0 = 0; exp_sel1 = 0; exp_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      bit stall, flush, valid, wr, ld;
      int rd, s0, s1;
      bit [1:0] used;
      stall = ($urandom_range(0, 99) < 15);
      flush = ($urandom_range(0, 99) < 10);
      valid = ($urandom_range(0, 99) < 80);
      wr    = ($urandom_range(0, 99) < 75);
      ld    = ($urandom_range(0, 99) < 35);
      rd    = $urandom_range(0, 3);
      s0    = $urandom_range(0, 3);
      s1    = $urandom_range(0, 3);
      used  = 2'($urandom_range(0, 3));
      @(negedge clk);
      apply(stall, flush, valid, wr, rd, ld, s0, s1, used);
      #1 check("rnd.lus", 32'(bus.load_use_stall),
               int'(m_lus(valid, flush, s0, s1, used)));
      model_step(stall, flush, valid, wr, rd, ld, s0, s1, used);
      @(posedge clk);
      #1;
      check("rnd.sel0", 32'(bus.fwd_sel[SELW-1:0]), exp_sel0);
      check("rnd.sel1", 32'(bus.fwd_sel[2*SELW-1:SELW]), exp_sel1);
      check("rnd.cnt", 32'(bus.pending_cnt), exp_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and hazard unit for the pipelined WISC core. It records the destination register of every in-flight writer in an internal shift pipeline that runs in lockstep with the EX..WB pipeline registers. It also computes registered per-operand bypass selects for the instruction entering EX, and raises a load-use stall when a consumer would need a load result before it exists. It sits beside the ID/EX boundary and replaces the purely combinational two-operand forward logic with a depth- and operand-count-generic block.

## Interface
- AW, 4: register address width.
- DEPTH, 3: tracked stages after ID (stage 0 = EX, 1 = MEM, ..., DEPTH-1 = WB); legal range 2..8.
- NUM_SRC, 2: source operands per instruction.
- ZERO_REG, 1: when 1, register 0 is never a forwarding source.
- SELW, derived, max(1, clog2(DEPTH)): select width.
- CW, derived, clog2(DEPTH+1): counter width.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  global pipeline freeze (e.g. memory wait); all state holds.
- flush  in  1  kill the instruction currently leaving ID (wrong path).
- issue_valid  in  1  instruction in ID is valid and requests issue to EX.
- issue_wr_en  in  1  that instruction writes a register.
- issue_rd  in  AW  its destination register.
- issue_is_load  in  1  its result is produced only at the end of MEM.
- src_addr  in  NUM_SRC*AW  source register addresses, operand i at bits [i*AW +: AW].
- src_used  in  NUM_SRC  operand i is actually read (immediate forms clear bit 1).
- load_use_stall  out  1  combinational; hold IF/ID and insert a bubble.
- fwd_sel  out  NUM_SRC*SELW  registered; selects the bypass for operand i of the EX instruction. 0 = register file, j = stage j pipeline result.
- pending_cnt  out  CW  number of valid writers currently tracked.

## Operation
- State:
  - Entry array e[0..DEPTH-1], each holding {v, rd, ld}.
  - fwd_sel register.
  - pending_cnt register.
- Match(i, k): src_used[k] & e[i].v & (e[i].rd == src_addr[k]) & ~(ZERO_REG & src_addr[k] == 0).
- load_use_stall = issue_valid & ~flush & OR over k of (Match(0, k) & e[0].ld).
- accept = issue_valid & ~flush & ~load_use_stall.
- Next select per operand k:
  - smallest i in 0..DEPTH-2 with Match(i, k) gives sel = i+1 (youngest producer wins);
  - no match gives 0.
  - Stage DEPTH-1 is never a source: the register file is write-through.
- Edge with stall=0:
  - e[i] <= e[i-1] for i ≥ 1; the old e[DEPTH-1] retires.
  - e[0] <= {accept & issue_wr_en & ~(ZERO_REG & issue_rd==0), issue_rd, issue_is_load}; if not accepted, e[0] is a bubble (v=0).
  - fwd_sel <= accept ? next select : 0.
  - pending_cnt <= popcount of the new e[].v.
- Edge with stall=1: e[], fwd_sel and pending_cnt hold. flush and issue are ignored; upstream holds them.
- load_use_stall is evaluated regardless of stall; upstream ORs it with stall.
- Writers to register 0 are never entered valid when ZERO_REG=1.

## Timing
- Reset (async, immediate): all e[].v=0, fwd_sel=0, pending_cnt=0; load_use_stall follows combinationally, so it is 0.
- fwd_sel is valid in the cycle the accepted instruction occupies EX, one edge after accept.
- A load-use hazard costs exactly one bubble:
  - cycle t: stall asserted.
  - t+1: the load is in e[1]; the consumer is accepted with sel=2.
- pending_cnt is updated on the same edge as the shift.
- Reset asserted mid-operation clears all in-flight tracking; the first accepted instruction after rst falls sees sel=0.
- Simultaneous flush and load_use match: flush wins, so load_use_stall=0 and a bubble is inserted.

## Test plan
- ADD R3 accepted at t, SUB R1,R3,R2 accepted at t+1 -> fwd_sel operand0 = 1 at t+2, operand1 = 0.
- ADD R3, NOP, SUB using R3 as operand1 -> fwd_sel operand1 = 2. With DEPTH=3, a producer three ahead -> 0.
- ADD R3 then ADD R3 then consumer of R3 -> sel = 1 (youngest wins, not 2).
- LW R5 at t, ADD R6,R5,R5 presented at t+1:
  - load_use_stall=1 for one cycle, bubble enters e[0];
  - consumer accepted at t+2 with both sels = 2;
  - pending_cnt goes 1, 1, 2.
- Producer R4 then consumer with stall held 3 cycles in between -> e[], fwd_sel and pending_cnt frozen; the result after release is identical to the no-stall run. Also: flush with a matching load -> no stall, bubble inserted.
- Writer to R0 with ZERO_REG=1 -> pending_cnt unchanged and consumer sel = 0. Assert rst with 3 writers in flight -> pending_cnt=0 and fwd_sel=0 immediately, before the next edge.
